// File: rtl/b1_insert_if.sv
// Bundles the serial frame stream, B1 calculator handshake and inserter outputs.
// master drives the frame and calculator inputs; slave is the inserter itself.
interface b1_insert_if;
  logic       sof;
  logic       sdi;
  logic [7:0] b1pdo;
  logic       b1vld;
  logic       insen;
  logic [7:0] b1inv;
  logic       sdo;
  logic       sofo;
  logic       b1pos;
  logic       frmerr;

  modport master (
    output sof, sdi, b1pdo, b1vld, insen, b1inv,
    input  sdo, sofo, b1pos, frmerr
  );

  modport slave (
    input  sof, sdi, b1pdo, b1vld, insen, b1inv,
    output sdo, sofo, b1pos, frmerr
  );
endinterface

// File: rtl/b1_insert.sv
// STM-1 serial B1 inserter: tracks the bit position within the 19440-bit frame
// and overwrites the B1 byte with the BIP-8 of the previous frame.
// A byte arriving while the B1 window is on air is parked until the window
// closes, so one transmitted B1 byte never mixes bits from two sources.
module b1_insert #(
  parameter int FRMBITS = 19440,
  parameter int B1BIT   = 2160,
  parameter int CNTW    = 15
) (
  input logic        clk155,
  input logic        rst,
  b1_insert_if.slave bus
);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] pos;
  logic [7:0]      held_q;
  logic [7:0]      staged_q;
  logic            pend_q;
  logic            vld_q;
  logic            synced_q;
  logic            sdo_q, sofo_q, b1pos_q, frmerr_q;
  logic            win;
  logic            rise;
  logic [2:0]      k;

  // Current bit position (sof forces realignment), window decode and edge detect.
  always_comb begin
    pos   = bus.sof ? '0 : cnt_q;
    cnt_d = (pos == CNTW'(FRMBITS - 1)) ? '0 : pos + CNTW'(1);
    win   = (pos >= CNTW'(B1BIT)) && (pos <= CNTW'(B1BIT + 7));
    k     = 3'(pos - CNTW'(B1BIT));
    rise  = bus.b1vld && !vld_q;
  end

  // Position counter and frame-error detection; first sof after reset only aligns.
  always_ff @(posedge clk155) begin
    if (rst) begin
      cnt_q    <= '0;
      synced_q <= 1'b0;
      frmerr_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      frmerr_q <= bus.sof && synced_q && (cnt_q != '0);
      if (bus.sof) synced_q <= 1'b1;
    end
  end

  // B1 byte capture; a rise inside the window is staged and applied once it closes.
  always_ff @(posedge clk155) begin
    if (rst) begin
      held_q   <= 8'h00;
      staged_q <= 8'h00;
      pend_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      vld_q <= bus.b1vld;
      if (pend_q && !win) begin
        held_q <= staged_q;
        pend_q <= 1'b0;
      end
      if (rise) begin
        if (win) begin
          staged_q <= bus.b1pdo;
          pend_q   <= 1'b1;
        end else begin
          held_q   <= bus.b1pdo;
          pend_q   <= 1'b0;
        end
      end
    end
  end

  // Registered serial output with B1 substitution and error-injection mask.
  always_ff @(posedge clk155) begin
    if (rst) begin
      sdo_q   <= 1'b0;
      sofo_q  <= 1'b0;
      b1pos_q <= 1'b0;
    end else begin
      sdo_q   <= (win && bus.insen) ? (held_q[k] ^ bus.b1inv[k]) : bus.sdi;
      sofo_q  <= bus.sof;
      b1pos_q <= win && bus.insen;
    end
  end

  assign bus.sdo    = sdo_q;
  assign bus.sofo   = sofo_q;
  assign bus.b1pos  = b1pos_q;
  assign bus.frmerr = frmerr_q;

endmodule

// File: tb/tb_b1_insert.sv
// Bench for b1_insert: every cycle is checked against a frame-position model
// derived from elapsed clocks since the last alignment point, plus directed
// checks on the B1 byte seen on sdo.
module tb_b1_insert;
  localparam int FRM = 19440;
  localparam int B1P = 2160;

  logic clk155 = 1'b0;
  logic rst    = 1'b1;
  b1_insert_if bus ();

  b1_insert dut (.clk155(clk155), .rst(rst), .bus(bus));

  always #3 clk155 = ~clk155;

  int total = 0;
  int bad   = 0;

  // model state
  int unsigned mc     = 0;
  int unsigned anchor = 0;
  bit          seen_sof = 0;
  bit          prev_vld = 0;
  bit          pend_m   = 0;
  logic [7:0]  held_m   = 8'h00;
  logic [7:0]  staged_m = 8'h00;

  task automatic chk_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h edge=%0d", tag, got, exp, mc);
    end
  endtask

  // One clock: predict outputs from the inputs presented, clock, then compare.
  task automatic step();
    int   p;
    int   kk;
    bit   w;
    bit   rise;
    logic e_sdo, e_sofo, e_b1pos, e_frmerr;
    e_sdo = 0; e_sofo = 0; e_b1pos = 0; e_frmerr = 0;
    if (rst) begin
      held_m = 8'h00; pend_m = 0; prev_vld = 0; seen_sof = 0;
      anchor = mc + 1;
    end else begin
      p = bus.sof ? 0 : int'((mc - anchor) % FRM);
      e_frmerr = bus.sof && seen_sof && (((mc - anchor) % FRM) != 0);
      if (bus.sof) begin
        seen_sof = 1;
        anchor = mc;
      end
      w  = (p >= B1P) && (p < B1P + 8);
      kk = w ? p - B1P : 0;
      e_b1pos = w && bus.insen;
      e_sdo   = e_b1pos ? (held_m[kk] ^ bus.b1inv[kk]) : bus.sdi;
      e_sofo  = bus.sof;
      rise = bus.b1vld && !prev_vld;
      prev_vld = bus.b1vld;
      if (pend_m && !w) begin
        held_m = staged_m;
        pend_m = 0;
      end
      if (rise) begin
        if (w) begin
          pend_m = 1;
          staged_m = bus.b1pdo;
        end else held_m = bus.b1pdo;
      end
    end
    mc++;
    @(posedge clk155);
    #1;
    chk_val("sdo",    16'(bus.sdo),    16'(e_sdo));
    chk_val("sofo",   16'(bus.sofo),   16'(e_sofo));
    chk_val("b1pos",  16'(bus.b1pos),  16'(e_b1pos));
    chk_val("frmerr", 16'(bus.frmerr), 16'(e_frmerr));
  endtask

  // Run ncyc clocks from an optional sof; collect the sdo byte at B1 positions.
  task automatic run_frame(input int ncyc, input bit do_sof, input int vld_pos,
                           input logic [7:0] vld_byte, input bit rnd,
                           output logic [7:0] wbyte, output int npw, output int npt,
                           output logic ferr0);
    wbyte = 8'h00; npw = 0; npt = 0; ferr0 = 0;
    for (int i = 0; i < ncyc; i++) begin
      bus.sof   = do_sof && (i == 0);
      bus.b1vld = (vld_pos >= 0) && (i >= vld_pos) && (i < vld_pos + 8);
      bus.b1pdo = vld_byte;
      bus.sdi   = rnd ? 1'($urandom) : 1'b1;
      step();
      if (i == 0) ferr0 = bus.frmerr;
      if (i >= B1P && i < B1P + 8) begin
        wbyte[i - B1P] = bus.sdo;
        if (bus.b1pos) npw++;
      end
      if (bus.b1pos) npt++;
    end
    bus.sof = 0;
    bus.b1vld = 0;
  endtask

  logic [7:0] wb;
  int         npw, npt;
  logic       fe;
  int         vc;

  initial begin
    bus.sof = 0; bus.sdi = 0; bus.b1pdo = 0; bus.b1vld = 0;
    bus.insen = 1; bus.b1inv = 8'h00;
    rst = 1;
    for (int i = 0; i < 3; i++) step();
    chk_val("rst_sdo", 16'(bus.sdo), 16'h0);
    rst = 0;

    // no calculator byte yet: B1 goes out as 00
    run_frame(2200, 1, -1, 8'h00, 0, wb, npw, npt, fe);
    chk_val("b1_zero", 16'(wb), 16'h00);
    chk_val("npos_a",  16'(npt), 16'd8);
    chk_val("nposw_a", 16'(npw), 16'd8);

    run_frame(2200, 1, 1, 8'hA5, 0, wb, npw, npt, fe);
    chk_val("b1_a5", 16'(wb), 16'hA5);
    chk_val("ferr_inj_b", 16'(fe), 16'h1);

    bus.b1inv = 8'h01;
    run_frame(2200, 1, 1, 8'hA5, 0, wb, npw, npt, fe);
    chk_val("b1_a5_inv", 16'(wb), 16'hA4);
    bus.b1inv = 8'h00;

    bus.insen = 0;
    run_frame(2200, 1, 1, 8'hA5, 0, wb, npw, npt, fe);
    chk_val("b1_off", 16'(wb), 16'hFF);
    chk_val("npos_off", 16'(npt), 16'd0);
    bus.insen = 1;

    // capture arriving mid-window is deferred to the next frame
    run_frame(2200, 1, 1, 8'hFF, 0, wb, npw, npt, fe);
    chk_val("b1_ff", 16'(wb), 16'hFF);
    run_frame(2200, 1, B1P + 3, 8'h3C, 0, wb, npw, npt, fe);
    chk_val("b1_defer_cur", 16'(wb), 16'hFF);
    run_frame(2200, 1, -1, 8'h00, 0, wb, npw, npt, fe);
    chk_val("b1_defer_next", 16'(wb), 16'h3C);

    // periodic frame, then sof injected at cnt=5000
    run_frame(FRM, 1, -1, 8'h00, 1, wb, npw, npt, fe);
    run_frame(5000, 1, -1, 8'h00, 1, wb, npw, npt, fe);
    chk_val("ferr_wrap", 16'(fe), 16'h0);
    run_frame(2200, 1, -1, 8'h00, 1, wb, npw, npt, fe);
    chk_val("ferr_inj", 16'(fe), 16'h1);
    chk_val("nposw_inj", 16'(npw), 16'd8);
    chk_val("npos_inj", 16'(npt), 16'd8);

    // reset mid-window, then free-run without sof
    run_frame(B1P + 4, 1, -1, 8'h00, 0, wb, npw, npt, fe);
    rst = 1;
    step();
    chk_val("rst_mid_sdo",   16'(bus.sdo),   16'h0);
    chk_val("rst_mid_b1pos", 16'(bus.b1pos), 16'h0);
    rst = 0;
    run_frame(2200, 0, -1, 8'h00, 0, wb, npw, npt, fe);
    chk_val("nposw_free", 16'(npw), 16'd8);
    chk_val("b1_free", 16'(wb), 16'h00);

    // randomized traffic
    vc = 0;
    for (int i = 0; i < 30000; i++) begin
      bus.sof = ($urandom_range(0, 2499) == 0);
      bus.sdi = 1'($urandom);
      if (vc == 0 && $urandom_range(0, 399) == 0) begin
        vc = $urandom_range(1, 20);
        bus.b1pdo = 8'($urandom);
      end
      bus.b1vld = (vc > 0);
      if (vc > 0) vc--;
      if ($urandom_range(0, 299) == 0) bus.insen = ~bus.insen;
      if ($urandom_range(0, 199) == 0) bus.b1inv = 8'($urandom);
      rst = ($urandom_range(0, 14999) == 0);
      step();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/b1_insert.md
Name: b1_insert

Overview:
- Serial-domain B1 inserter in the STM-1 transmit path at 155.52 Mb/s, one bit per clk155.
- Tracks bit position within the 19440-bit STM-1 frame and overwrites the B1 byte (row 2, column 1; frame byte 270) of frame N with the BIP-8 byte computed over frame N-1.
- Sits upstream of the frame scrambler. Consumes the parallel B1 byte and valid strobe from the B1 calculator, which sits downstream of the scrambler.

Parameters:
- FRMBITS, 19440, bits per STM-1 frame; counter wraps at FRMBITS-1.
- B1BIT, 2160, position of the first B1 bit (byte 270 x 8).
- CNTW, 15, width of the bit-position counter.

Ports:
- clk155  in  1  155.52 MHz bit clock.
- rst  in  1  reset, synchronous, active-high.
- sof  in  1  start-of-frame; high with the first bit (A1 bit 0) of a frame on sdi.
- sdi  in  1  serial frame data, unscrambled.
- b1pdo  in  8  B1 byte from the calculator; bit k is the k-th transmitted bit of the byte.
- b1vld  in  1  calculator valid; rises the cycle after sof, high for 8 clocks.
- insen  in  1  1 = insert B1; 0 = pass sdi through unchanged.
- b1inv  in  8  error-injection XOR mask applied to the inserted byte.
- sdo  out  1  serial data with B1 inserted.
- sofo  out  1  sof delayed to align with sdo.
- b1pos  out  1  high while sdo carries the 8 B1 bits.
- frmerr  out  1  1-cycle pulse: sof arrived at a position other than the expected frame start.

Behaviour:
- Reset (synchronous, any time including mid-frame):
  - cnt=0, held B1 byte=8'h00, pending flag=0.
  - sdo=0, sofo=0, b1pos=0, frmerr=0.
- Position: pos = sof ? 0 : cnt. Next cnt = (pos==FRMBITS-1) ? 0 : pos+1.
  - With no sof, the block free-runs and realigns at the next sof.
- Frame error: frmerr<=1 for one cycle when sof=1 and cnt!=0.
  - Not raised on the first sof after reset.
  - Not raised when sof lands exactly at the wrap point (cnt==0).
- B1 window: win = (pos >= B1BIT) && (pos <= B1BIT+7). Bit index k = pos-B1BIT.
- Capture: on a b1vld rising edge (b1vld && !b1vld_d), held<=b1pdo.
  - If the rising edge falls inside win, capture is deferred: pending<=1, staged<=b1pdo.
  - The staged value loads into held on the first cycle with win=0.
  - Guarantees one B1 byte is never mixed from two sources.
- Output, 1-cycle latency, all registered:
  - sdo <= (win && insen) ? (held[k] ^ b1inv[k]) : sdi.
  - sofo <= sof. b1pos <= win && insen.
- insen and b1inv are sampled per bit. Changing them mid-window affects only the remaining bits.
- First frame after reset: held=00, so B1 is sent as 00 (^ b1inv).
- b1vld held high longer than 8 clocks: only the rising edge captures.
- Simultaneous sof and b1vld rise: handled independently; the capture still occurs.

Test Plan:
- Reset, then sof at t0, sdi=1 constant, insen=1, b1inv=00, b1vld never asserted:
  - sdo=1 except bits 2160..2167 of every frame, which are 0.
  - b1pos high 8 cycles starting at t0+2161.
  - sofo at t0+1.
- Pulse b1vld at t0+1 with b1pdo=8'hA5, insen=1, b1inv=00:
  - Frame bits 2160..2167 on sdo are 1,0,1,0,0,1,0,1 (b1pdo[0] first).
- Same stimulus with b1inv=8'h01: sdo B1 bits are 0,0,1,0,0,1,0,1.
- Same stimulus with insen=0: sdo == sdi delayed 1 cycle, and b1pos stays 0.
- Periodic sof every 19440 cycles, then one sof injected at cnt=5000:
  - frmerr pulses once, one cycle after the injected sof.
  - The next B1 window starts 2160 cycles after the injected sof.
- b1vld rises at pos 2163 with b1pdo=8'h3C while held=8'hFF:
  - The current window sends all 1s.
  - The next frame's B1 sends 3C.
- Assert rst at pos 2164: sdo=0 and b1pos=0 next cycle; after release with no sof, a B1 window appears at cnt=2160.
